eth_phy_10g_lite: RTL and testbench
===================================

Name: eth_phy_10g_lite

Overview:
- Single-clock 10GBASE-R PCS lite: 64-bit XGMII (8 lanes) to and from 64b/66b blocks with a 2-bit sync header.
- Contains TX encoder, RX decoder, block-lock/bitslip state machine and a simple BER monitor.
- Sits between the MAC (XGMII side) and a gearbox-equipped SERDES (66-bit block side).

Parameters:
- DATA_WIDTH, 64, XGMII and block payload width; only 64 is supported.
- CTRL_WIDTH, DATA_WIDTH/8, XGMII control bits, one per lane.
- HDR_WIDTH, 2, sync header width; SYNC_DATA=2'b10, SYNC_CTRL=2'b01.
- BITSLIP_HIGH_CYCLES, 1, cycles serdes_rx_bitslip is held high per slip.
- BITSLIP_LOW_CYCLES, 8, quiet cycles after a slip before headers are counted again.
- COUNT_125US, 19531, clock cycles per BER window (125000/6.4).

Ports:
- clk  in  1  single clock for TX and RX.
- rst_n  in  1  synchronous active-low reset.
- xgmii_txd  in  64  TX data; lane i = bits [8i+7:8i].
- xgmii_txc  in  8  TX control; bit i marks lane i as control.
- xgmii_rxd  out  64  RX data.
- xgmii_rxc  out  8  RX control.
- serdes_tx_data  out  64  TX block payload.
- serdes_tx_hdr  out  2  TX sync header.
- serdes_rx_data  in  64  RX block payload.
- serdes_rx_hdr  in  2  RX sync header.
- serdes_rx_bitslip  out  1  slip request to the SERDES.
- rx_error_count  out  7  errored blocks in the last BER window.
- rx_bad_block  out  1  one-cycle pulse per undecodable RX block.
- rx_block_lock  out  1  block lock achieved.
- rx_high_ber  out  1  high bit-error rate.

Behaviour:
- Reset values:
  - serdes_tx_data=64'h1E, serdes_tx_hdr=SYNC_CTRL (idle block).
  - xgmii_rxd=64'h0707070707070707, xgmii_rxc=8'hFF.
  - All status outputs 0.
- Control codes:
  - XGMII idle 0x07 maps to 7-bit 0x00; XGMII error 0xFE maps to 0x1E.
  - Any other control character encodes as 0x1E.
  - The 7-bit control code for lane i occupies payload bits [8+7i +: 7].
- TX encoding: 1-cycle registered latency.
  - txc=00: header SYNC_DATA, payload = txd.
  - txc=FF, no 0xFD lane: type 0x1E, eight 7-bit control codes.
  - txc=01 and lane0=0xFB: type 0x78, payload[63:8] = txd[63:8].
  - txc=1F, lane4=0xFB, lanes0-3 control: type 0x33, lanes0-3 codes in bits [35:8], bits [39:36]=0, payload[63:40] = txd[63:40].
  - Terminate in lane k (txc bits k..7 set, lane k=0xFD), k=0..7: type 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF respectively.
    - Payload bytes 1..k = txd lanes 0..k-1; remaining bits 0 (idle codes).
  - Any other txc/txd combination: type 0x1E with all codes 0x1E (error).
  - The block type is in payload[7:0] for every control block.
- RX decoding: exact inverse of TX encoding, 1-cycle registered latency.
  - Error block when the header is 00 or 11, the type is unknown, or rx_block_lock=0.
  - Error block output: xgmii_rxd=64'hFEFEFEFEFEFEFEFE, rxc=FF.
  - rx_bad_block=1 for that cycle, only while locked.
  - A decoded 7-bit control code other than 0x00 yields 0xFE in its lane.
- Block lock (header valid = 01 or 10):
  - SH_CNT counts headers 0..63; INV_CNT counts invalid headers.
  - Unlocked: any invalid header triggers a slip.
    - Slip: bitslip high BITSLIP_HIGH_CYCLES, then ignore headers BITSLIP_LOW_CYCLES, counters cleared.
    - 64 consecutive valid headers set rx_block_lock=1.
  - Locked: at the 64th header with INV_CNT<16, clear both counters.
  - Locked: when INV_CNT reaches 16, clear rx_block_lock the same cycle, slip, and clear counters.
  - Reset mid-operation clears counters and lock.
- BER monitor:
  - A free-running window counter wraps at COUNT_125US-1.
  - Invalid headers are counted while rx_block_lock=1, saturating at 127.
  - At wrap: rx_error_count = that count, and rx_high_ber = (count >= 16); the count is then cleared.
  - An invalid header arriving on the wrap cycle counts into the new window.

Optional Feature:
- ETH_PHY_SCRAMBLER_EN defined:
  - TX payload goes through a self-synchronizing scrambler, polynomial x^58+x^39+1, LSB first; state resets to all ones.
  - RX payload goes through the matching descrambler; headers are never scrambled.
  - Latency is unchanged (combinational in front of the registers).
- Undefined: payload passes unscrambled both ways.

Test Plan:
- Reset: hold rst_n=0 for 7 clocks -> serdes_tx_data=0x1E, serdes_tx_hdr=01, xgmii_rxc=FF, rx_block_lock=0.
- TX frame: txd=D5555555555555FB txc=01, then data D_DDDD_AAAD_DDDD txc=00, then FD2233EE44EEEFFF txc=80 -> next cycles produce:
  - type 78, payload D5555555555555 in [63:8];
  - SYNC_DATA block;
  - type FF, payload 2233EE44EEEFFF in [63:8].
- TX idle: txd=0707070707070707 txc=FF -> hdr 01, data 64'h1E.
- Lock: 64 valid RX headers -> rx_block_lock=1 on the 64th. Then an RX block hdr 01 data 0x1E -> rxd=0707..07, rxc=FF.
  - Header 00 while locked -> rxd=FEFE..FE and rx_bad_block pulse.
- Slip: unlocked, header 11 -> serdes_rx_bitslip=1 for 1 cycle, then no count for 8 cycles.
- BER: 16 invalid headers in one 125 us window while locked -> lock drops; at the window end rx_error_count=16 and rx_high_ber=1.

Source files
------------

// File: rtl/eth_phy_10g_lite_if.sv
// XGMII and 66-bit block-side bundle for eth_phy_10g_lite.
// slave = the PCS itself; master = the MAC/SERDES environment around it.
interface eth_phy_10g_lite_if;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = DW / 8;
  localparam int unsigned HW = 2;

  logic [DW-1:0] xgmii_txd;
  logic [CW-1:0] xgmii_txc;
  logic [DW-1:0] xgmii_rxd;
  logic [CW-1:0] xgmii_rxc;
  logic [DW-1:0] serdes_tx_data;
  logic [HW-1:0] serdes_tx_hdr;
  logic [DW-1:0] serdes_rx_data;
  logic [HW-1:0] serdes_rx_hdr;
  logic          serdes_rx_bitslip;
  logic [6:0]    rx_error_count;
  logic          rx_bad_block;
  logic          rx_block_lock;
  logic          rx_high_ber;

  modport slave (
    input  xgmii_txd, xgmii_txc, serdes_rx_data, serdes_rx_hdr,
    output xgmii_rxd, xgmii_rxc, serdes_tx_data, serdes_tx_hdr, serdes_rx_bitslip,
           rx_error_count, rx_bad_block, rx_block_lock, rx_high_ber
  );

  modport master (
    output xgmii_txd, xgmii_txc, serdes_rx_data, serdes_rx_hdr,
    input  xgmii_rxd, xgmii_rxc, serdes_tx_data, serdes_tx_hdr, serdes_rx_bitslip,
           rx_error_count, rx_bad_block, rx_block_lock, rx_high_ber
  );
endinterface

// File: rtl/eth_phy_10g_lite.sv
// 10GBASE-R PCS lite: XGMII <-> 64b/66b encode/decode, block lock with bitslip, BER monitor.
// Optional payload scrambling is enabled by defining ETH_PHY_SCRAMBLER_EN.
module eth_phy_10g_lite #(
  parameter int unsigned DATA_WIDTH          = 64,
  parameter int unsigned CTRL_WIDTH          = DATA_WIDTH / 8,
  parameter int unsigned HDR_WIDTH           = 2,
  parameter int unsigned BITSLIP_HIGH_CYCLES = 1,
  parameter int unsigned BITSLIP_LOW_CYCLES  = 8,
  parameter int unsigned COUNT_125US         = 19531
) (
  input logic               clk,
  input logic               rst_n,
  eth_phy_10g_lite_if.slave bus
);
  localparam logic [HDR_WIDTH-1:0]  SYNC_DATA = 2'b10;
  localparam logic [HDR_WIDTH-1:0]  SYNC_CTRL = 2'b01;
  localparam logic [DATA_WIDTH-1:0] ERR_BLOCK = {{8{7'h1E}}, 8'h1E};
  localparam int unsigned TMR_W = $clog2(BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES + 1);
  localparam int unsigned WIN_W = $clog2(COUNT_125US);

  typedef enum logic [1:0] {ST_COUNT, ST_SLIP, ST_WAIT} lock_state_t;

  function automatic logic [6:0] enc7(input logic [7:0] c);
    return (c == 8'h07) ? 7'h00 : 7'h1E;
  endfunction

  function automatic logic [7:0] dec8(input logic [6:0] c);
    return (c == 7'h00) ? 8'h07 : 8'hFE;
  endfunction

  function automatic logic [7:0] term_type(input logic [2:0] k);
    case (k)
      3'd0: return 8'h87;
      3'd1: return 8'h99;
      3'd2: return 8'hAA;
      3'd3: return 8'hB4;
      3'd4: return 8'hCC;
      3'd5: return 8'hD2;
      3'd6: return 8'hE1;
      default: return 8'hFF;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] enc_data, tx_pay, rx_pay, rx_shift, ctrl_pay, term_pay, dec_data;
  logic [HDR_WIDTH-1:0]  enc_hdr;
  logic [CTRL_WIDTH-1:0] dec_ctrl;
  logic [2:0]            term_k, dec_k;
  logic                  term_hit, has_fd, dec_term, dec_err, hdr_valid, ber_inc;

  logic [DATA_WIDTH-1:0] tx_data_q, rxd_q;
  logic [HDR_WIDTH-1:0]  tx_hdr_q;
  logic [CTRL_WIDTH-1:0] rxc_q;
  logic                  bad_q, lock_q, lock_nxt, slip_q;
  lock_state_t           state_q, state_nxt;
  logic [5:0]            sh_q, sh_nxt;
  logic [4:0]            inv_q, inv_nxt;
  logic [TMR_W-1:0]      tmr_q, tmr_nxt;
  logic [WIN_W-1:0]      win_q;
  logic [6:0]            ber_q, err_cnt_q;
  logic                  high_q;

  // TX block encoder
  always_comb begin
    enc_hdr  = SYNC_CTRL;
    enc_data = ERR_BLOCK;
    ctrl_pay = '0;
    term_pay = '0;
    term_hit = 1'b0;
    term_k   = '0;
    has_fd   = 1'b0;
    ctrl_pay[7:0] = 8'h1E;
    for (int i = 0; i < 8; i++) begin
      ctrl_pay[8 + 7*i +: 7] = enc7(bus.xgmii_txd[8*i +: 8]);
      if (bus.xgmii_txd[8*i +: 8] == 8'hFD) has_fd = 1'b1;
      if (bus.xgmii_txc == 8'(8'hFF << i) && bus.xgmii_txd[8*i +: 8] == 8'hFD) begin
        term_hit = 1'b1;
        term_k   = 3'(i);
      end
    end
    for (int j = 0; j < 7; j++)
      if (j < int'(term_k)) term_pay[8 + 8*j +: 8] = bus.xgmii_txd[8*j +: 8];
    term_pay[7:0] = term_type(term_k);

    if (bus.xgmii_txc == 8'h00) begin
      enc_hdr  = SYNC_DATA;
      enc_data = bus.xgmii_txd;
    end else if (term_hit) begin
      enc_data = term_pay;
    end else if (bus.xgmii_txc == 8'hFF && !has_fd) begin
      enc_data = ctrl_pay;
    end else if (bus.xgmii_txc == 8'h01 && bus.xgmii_txd[7:0] == 8'hFB) begin
      enc_data = {bus.xgmii_txd[63:8], 8'h78};
    end else if (bus.xgmii_txc == 8'h1F && bus.xgmii_txd[39:32] == 8'hFB) begin
      enc_data = {bus.xgmii_txd[63:40], 4'h0, ctrl_pay[35:8], 8'h33};
    end
  end

`ifdef ETH_PHY_SCRAMBLER_EN
  // Self-synchronizing x^58 + x^39 + 1, LSB first; RX side descrambles on received bits
  logic [57:0] scr_q, scr_nxt, dsc_q, dsc_nxt;
  always_comb begin
    tx_pay  = '0;
    rx_pay  = '0;
    scr_nxt = scr_q;
    dsc_nxt = dsc_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      tx_pay[i] = enc_data[i] ^ scr_nxt[38] ^ scr_nxt[57];
      scr_nxt   = {scr_nxt[56:0], tx_pay[i]};
      rx_pay[i] = bus.serdes_rx_data[i] ^ dsc_nxt[38] ^ dsc_nxt[57];
      dsc_nxt   = {dsc_nxt[56:0], bus.serdes_rx_data[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scr_q <= '1;
      dsc_q <= '1;
    end else begin
      scr_q <= scr_nxt;
      dsc_q <= dsc_nxt;
    end
  end
`else
  assign tx_pay = enc_data;
  assign rx_pay = bus.serdes_rx_data;
`endif

  // RX block decoder; anything undecodable or seen while unlocked becomes an error block
  always_comb begin
    dec_data = {CTRL_WIDTH{8'hFE}};
    dec_ctrl = '1;
    dec_err  = 1'b1;
    dec_term = 1'b0;
    dec_k    = '0;
    rx_shift = rx_pay >> 8;
    if (lock_q && bus.serdes_rx_hdr == SYNC_DATA) begin
      dec_data = rx_pay;
      dec_ctrl = '0;
      dec_err  = 1'b0;
    end else if (lock_q && bus.serdes_rx_hdr == SYNC_CTRL) begin
      case (rx_pay[7:0])
        8'h1E: begin
          for (int i = 0; i < 8; i++) dec_data[8*i +: 8] = dec8(rx_pay[8 + 7*i +: 7]);
          dec_err = 1'b0;
        end
        8'h78: begin
          dec_data = {rx_pay[63:8], 8'hFB};
          dec_ctrl = 8'h01;
          dec_err  = 1'b0;
        end
        8'h33: begin
          for (int i = 0; i < 4; i++) dec_data[8*i +: 8] = dec8(rx_pay[8 + 7*i +: 7]);
          dec_data[63:32] = {rx_pay[63:40], 8'hFB};
          dec_ctrl = 8'h1F;
          dec_err  = 1'b0;
        end
        8'h87: begin dec_term = 1'b1; dec_k = 3'd0; end
        8'h99: begin dec_term = 1'b1; dec_k = 3'd1; end
        8'hAA: begin dec_term = 1'b1; dec_k = 3'd2; end
        8'hB4: begin dec_term = 1'b1; dec_k = 3'd3; end
        8'hCC: begin dec_term = 1'b1; dec_k = 3'd4; end
        8'hD2: begin dec_term = 1'b1; dec_k = 3'd5; end
        8'hE1: begin dec_term = 1'b1; dec_k = 3'd6; end
        8'hFF: begin dec_term = 1'b1; dec_k = 3'd7; end
        default: ;
      endcase
      if (dec_term) begin
        for (int j = 0; j < 8; j++) begin
          if (j < int'(dec_k))       dec_data[8*j +: 8] = rx_shift[8*j +: 8];
          else if (j == int'(dec_k)) dec_data[8*j +: 8] = 8'hFD;
          else                       dec_data[8*j +: 8] = 8'h07;
        end
        dec_ctrl = 8'(8'hFF << dec_k);
        dec_err  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data_q <= DATA_WIDTH'(64'h1E);
      tx_hdr_q  <= SYNC_CTRL;
      rxd_q     <= {CTRL_WIDTH{8'h07}};
      rxc_q     <= '1;
      bad_q     <= 1'b0;
    end else begin
      tx_data_q <= tx_pay;
      tx_hdr_q  <= enc_hdr;
      rxd_q     <= dec_data;
      rxc_q     <= dec_ctrl;
      bad_q     <= dec_err & lock_q;
    end
  end

  assign hdr_valid = (bus.serdes_rx_hdr == SYNC_DATA) || (bus.serdes_rx_hdr == SYNC_CTRL);

  // Block lock: headers are ignored during the slip pulse and the quiet period after it
  always_comb begin
    state_nxt = state_q;
    sh_nxt    = sh_q;
    inv_nxt   = inv_q;
    tmr_nxt   = tmr_q;
    lock_nxt  = lock_q;
    case (state_q)
      ST_COUNT: begin
        if (!hdr_valid && (!lock_q || inv_q == 5'd15)) begin
          lock_nxt  = 1'b0;
          state_nxt = ST_SLIP;
          sh_nxt    = '0;
          inv_nxt   = '0;
          tmr_nxt   = '0;
        end else if (sh_q == 6'd63) begin
          lock_nxt = 1'b1;
          sh_nxt   = '0;
          inv_nxt  = '0;
        end else begin
          sh_nxt = sh_q + 6'd1;
          if (!hdr_valid) inv_nxt = inv_q + 5'd1;
        end
      end
      ST_SLIP: begin
        tmr_nxt = tmr_q + TMR_W'(1);
        if (tmr_q == TMR_W'(BITSLIP_HIGH_CYCLES - 1)) begin
          state_nxt = ST_WAIT;
          tmr_nxt   = '0;
        end
      end
      ST_WAIT: begin
        tmr_nxt = tmr_q + TMR_W'(1);
        if (tmr_q == TMR_W'(BITSLIP_LOW_CYCLES - 1)) begin
          state_nxt = ST_COUNT;
          tmr_nxt   = '0;
        end
      end
      default: state_nxt = ST_COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COUNT;
      sh_q    <= '0;
      inv_q   <= '0;
      tmr_q   <= '0;
      lock_q  <= 1'b0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      sh_q    <= sh_nxt;
      inv_q   <= inv_nxt;
      tmr_q   <= tmr_nxt;
      lock_q  <= lock_nxt;
      slip_q  <= (state_nxt == ST_SLIP);
    end
  end

  // BER window: a bad header on the wrap cycle seeds the next window
  assign ber_inc = lock_q && !hdr_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q     <= '0;
      ber_q     <= '0;
      err_cnt_q <= '0;
      high_q    <= 1'b0;
    end else if (win_q == WIN_W'(COUNT_125US - 1)) begin
      win_q     <= '0;
      err_cnt_q <= ber_q;
      high_q    <= (ber_q >= 7'd16);
      ber_q     <= {6'd0, ber_inc};
    end else begin
      win_q <= win_q + WIN_W'(1);
      if (ber_inc && ber_q != 7'd127) ber_q <= ber_q + 7'd1;
    end
  end

  assign bus.serdes_tx_data    = tx_data_q;
  assign bus.serdes_tx_hdr     = tx_hdr_q;
  assign bus.xgmii_rxd         = rxd_q;
  assign bus.xgmii_rxc         = rxc_q;
  assign bus.rx_bad_block      = bad_q;
  assign bus.rx_block_lock     = lock_q;
  assign bus.serdes_rx_bitslip = slip_q;
  assign bus.rx_error_count    = err_cnt_q;
  assign bus.rx_high_ber       = high_q;
endmodule

// File: tb/tb_eth_phy_10g_lite.sv
// Directed self-checking bench for eth_phy_10g_lite (default build, no scrambler).
module tb_eth_phy_10g_lite;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_phy_10g_lite_if bus ();
  eth_phy_10g_lite dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int passed = 0;

  localparam int NTX = 9;
  localparam logic [63:0] TX_D [NTX] = '{
    64'hD5555555555555FB, 64'hDDDDDDDDAAADDDDD, 64'hFD2233EE44EEEFFF,
    64'h0707070707070707, 64'h070707070707FE07, 64'h07070707070707FD,
    64'h07070707FD332211, 64'h665544FB07070707, 64'h0707070707070707};
  localparam logic [7:0]  TX_C [NTX] = '{8'h01, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'h1F, 8'h01};
  localparam logic [1:0]  TX_H [NTX] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
  localparam logic [63:0] TX_E [NTX] = '{
    64'hD555555555555578, 64'hDDDDDDDDAAADDDDD, 64'h2233EE44EEEFFFFF,
    64'h000000000000001E, 64'h00000000000F001E, 64'h0000000000000087,
    64'h00000000332211B4, 64'h6655440000000033, {{8{7'h1E}}, 8'h1E}};

  localparam int NRX = 10;
  localparam logic [1:0]  RX_H [NRX] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
  localparam logic [63:0] RX_D [NRX] = '{
    64'h000000000000001E, 64'h1122334455667788, 64'hD555555555555578,
    64'h00000000332211B4, 64'h6655440000000033, 64'h2233EE44EEEFFFFF,
    64'h00000000000F001E, 64'h0000000000000055, 64'h0000000000000000,
    64'h000000000000001E};
  localparam logic [63:0] RX_E [NRX] = '{
    64'h0707070707070707, 64'h1122334455667788, 64'hD5555555555555FB,
    64'h07070707FD332211, 64'h665544FB07070707, 64'hFD2233EE44EEEFFF,
    64'h070707070707FE07, 64'hFEFEFEFEFEFEFEFE, 64'hFEFEFEFEFEFEFEFE,
    64'h0707070707070707};
  localparam logic [7:0]  RX_C [NRX] = '{8'hFF, 8'h00, 8'h01, 8'hF8, 8'h1F, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  localparam logic        RX_B [NRX] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.xgmii_txd      = 64'h0707070707070707;
    bus.xgmii_txc      = 8'hFF;
    bus.serdes_rx_hdr  = 2'b01;
    bus.serdes_rx_data = 64'h1E;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (7) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (7) tick();
    checks++; if (bus.serdes_tx_data !== 64'h1E) $display("FAIL reset_tx_data: got %h expected %h", bus.serdes_tx_data, 64'h1E); else passed++;
    checks++; if (bus.serdes_tx_hdr !== 2'b01) $display("FAIL reset_tx_hdr: got %b expected 01", bus.serdes_tx_hdr); else passed++;
    checks++; if (bus.xgmii_rxd !== 64'h0707070707070707) $display("FAIL reset_rxd: got %h expected 0707070707070707", bus.xgmii_rxd); else passed++;
    checks++; if (bus.xgmii_rxc !== 8'hFF) $display("FAIL reset_rxc: got %h expected ff", bus.xgmii_rxc); else passed++;
    checks++; if ({bus.rx_block_lock, bus.serdes_rx_bitslip, bus.rx_bad_block, bus.rx_high_ber, bus.rx_error_count} !== 11'd0)
      $display("FAIL reset_status: got lock=%b slip=%b bad=%b high=%b cnt=%0d expected all 0",
               bus.rx_block_lock, bus.serdes_rx_bitslip, bus.rx_bad_block, bus.rx_high_ber, bus.rx_error_count);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_tx_encode();
    for (int i = 0; i < NTX; i++) begin
      bus.xgmii_txd = TX_D[i];
      bus.xgmii_txc = TX_C[i];
      tick();
      checks++; if (bus.serdes_tx_hdr !== TX_H[i]) $display("FAIL tx_hdr[%0d]: got %b expected %b", i, bus.serdes_tx_hdr, TX_H[i]); else passed++;
      checks++; if (bus.serdes_tx_data !== TX_E[i]) $display("FAIL tx_data[%0d]: got %h expected %h", i, bus.serdes_tx_data, TX_E[i]); else passed++;
    end
    drive_idle();
  endtask

  task automatic test_lock();
    apply_reset();
    repeat (63) tick();
    checks++; if (bus.rx_block_lock !== 1'b0) $display("FAIL lock_early: got %b expected 0 after 63 headers", bus.rx_block_lock); else passed++;
    tick();
    checks++; if (bus.rx_block_lock !== 1'b1) $display("FAIL lock_64: got %b expected 1 after 64 headers", bus.rx_block_lock); else passed++;
    checks++; if (bus.xgmii_rxd !== 64'hFEFEFEFEFEFEFEFE) $display("FAIL unlocked_rxd: got %h expected fefefefefefefefe", bus.xgmii_rxd); else passed++;
    checks++; if (bus.rx_bad_block !== 1'b0) $display("FAIL unlocked_bad: got %b expected 0", bus.rx_bad_block); else passed++;
  endtask

  task automatic test_rx_decode();
    for (int i = 0; i < NRX; i++) begin
      bus.serdes_rx_hdr  = RX_H[i];
      bus.serdes_rx_data = RX_D[i];
      tick();
      checks++; if (bus.xgmii_rxd !== RX_E[i]) $display("FAIL rx_data[%0d]: got %h expected %h", i, bus.xgmii_rxd, RX_E[i]); else passed++;
      checks++; if (bus.xgmii_rxc !== RX_C[i]) $display("FAIL rx_ctrl[%0d]: got %h expected %h", i, bus.xgmii_rxc, RX_C[i]); else passed++;
      checks++; if (bus.rx_bad_block !== RX_B[i]) $display("FAIL rx_bad[%0d]: got %b expected %b", i, bus.rx_bad_block, RX_B[i]); else passed++;
    end
    checks++; if (bus.rx_block_lock !== 1'b1) $display("FAIL rx_lock_held: got %b expected 1", bus.rx_block_lock); else passed++;
    drive_idle();
  endtask

  task automatic test_slip();
    int bad_cycles;
    apply_reset();
    bus.serdes_rx_hdr = 2'b11;
    tick();
    checks++; if (bus.serdes_rx_bitslip !== 1'b1) $display("FAIL slip_pulse: got %b expected 1", bus.serdes_rx_bitslip); else passed++;
    bad_cycles = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.serdes_rx_bitslip !== 1'b0) bad_cycles++;
    end
    checks++; if (bad_cycles != 0) $display("FAIL slip_quiet: got %0d slip cycles expected 0", bad_cycles); else passed++;
    tick();
    checks++; if (bus.serdes_rx_bitslip !== 1'b1) $display("FAIL slip_again: got %b expected 1", bus.serdes_rx_bitslip); else passed++;
    bus.serdes_rx_hdr = 2'b10;
    repeat (72) tick();
    checks++; if (bus.rx_block_lock !== 1'b0) $display("FAIL relock_early: got %b expected 0", bus.rx_block_lock); else passed++;
    tick();
    checks++; if (bus.rx_block_lock !== 1'b1) $display("FAIL relock: got %b expected 1", bus.rx_block_lock); else passed++;
    drive_idle();
  endtask

  task automatic test_ber();
    int n;
    apply_reset();
    repeat (64) tick();
    checks++; if (bus.rx_block_lock !== 1'b1) $display("FAIL ber_lock: got %b expected 1", bus.rx_block_lock); else passed++;
    bus.serdes_rx_hdr = 2'b00;
    repeat (15) tick();
    checks++; if (bus.rx_block_lock !== 1'b1) $display("FAIL ber_lock_15: got %b expected 1", bus.rx_block_lock); else passed++;
    tick();
    checks++; if (bus.rx_block_lock !== 1'b0) $display("FAIL ber_lock_16: got %b expected 0", bus.rx_block_lock); else passed++;
    bus.serdes_rx_hdr = 2'b01;
    n = 0;
    while (bus.rx_error_count == 7'd0 && n < 20000) begin
      tick();
      n++;
    end
    checks++; if (n != 19451) $display("FAIL ber_window: got %0d cycles expected 19451", n); else passed++;
    checks++; if (bus.rx_error_count !== 7'd16) $display("FAIL ber_count: got %0d expected 16", bus.rx_error_count); else passed++;
    checks++; if (bus.rx_high_ber !== 1'b1) $display("FAIL ber_high: got %b expected 1", bus.rx_high_ber); else passed++;
  endtask

  initial begin
    test_reset();
    test_tx_encode();
    test_lock();
    test_rx_decode();
    test_slip();
    test_ber();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
